mp3dec_stream_ctrl: RTL

//  Sequencer between host word stream and Mp3Decode core. Buffers 32-bit MP3 words in a show-ahead FIFO.

---
 rtl/mp3dec_pkg.sv | 23 ++
 rtl/mp3dec_word_fifo.sv | 67 ++++++
 rtl/mp3dec_stream_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mp3dec_pkg.sv
// Shared types and constants for the MP3 decoder stream controller.
package mp3dec_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RSTD  = 3'd1,
    PRIME = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } ctrl_state_t;

  // Layer III frames carry two granules; frame_count advances on every second granule edge.
  localparam int unsigned GRANULES_PER_FRAME = 2;
  localparam int unsigned GRAN_CNT_W         = $clog2(GRANULES_PER_FRAME);

  // States in which a stream is in progress.
  function automatic logic is_busy(input ctrl_state_t s);
    return (s == RSTD) || (s == PRIME) || (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/mp3dec_word_fifo.sv
// Synchronous show-ahead word FIFO. The head word is presented combinationally,
// so a word pushed into an empty FIFO is visible the cycle after the push. When
// the FIFO runs empty the output holds the last popped word instead of stale RAM.
module mp3dec_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a word when a pop frees a slot in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? last_q : mem_q[rd_ptr_q];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers, occupancy and last-popped word; flush empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mp3dec_stream_ctrl.sv
// Stream sequencer between the host word stream and the Mp3Decode core:
// buffers words, sequences decoder reset/enable, counts frames and underruns,
// detects end of stream and retries the decoder on Invalid_format.
module mp3dec_stream_ctrl #(
  parameter int DEPTH       = 16,
  parameter int RST_CYCLES  = 8,
  parameter int PRIME_WORDS = 8,
  parameter int DRAIN_TMO   = 4096,
  parameter int MAX_RETRY   = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] host_wdata,
  input  logic        host_wvalid,
  input  logic        host_eos,
  output logic        host_wready,
  output logic        dec_rst_n,
  output logic        dec_enable,
  output logic        dec_fifo_empty,
  output logic [31:0] dec_fifo_datain,
  input  logic        dec_fifo_ren,
  input  logic        dec_invalid,
  input  logic        dec_granule_done,
  input  logic        sink_full,
  output logic        dec_wfull,
  output logic [2:0]  state_o,
  output logic [31:0] frame_count,
  output logic [15:0] underrun_count,
  output logic        busy,
  output logic        done,
  output logic        error
);

  import mp3dec_pkg::*;

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int TMR_MAX = (DRAIN_TMO > RST_CYCLES) ? DRAIN_TMO : RST_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  ctrl_state_t           state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic                  eos_seen_q, eos_seen_d;
  logic                  pend_q, pend_d;
  logic                  gran_prev_q;
  logic [GRAN_CNT_W-1:0] gran_par_q, gran_par_d;
  logic [31:0]           frame_q, frame_d;
  logic [15:0]           underrun_q, underrun_d;

  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             gran_edge, accept_ok, stop_hit, clear_counts;

  assign gran_edge = dec_granule_done & ~gran_prev_q;
  // The decoder only sees data in RUN, so reads outside RUN never consume words.
  assign fifo_pop    = dec_fifo_ren & ~fifo_empty & (state_q == RUN);
  assign accept_ok   = ((state_q == PRIME) || (state_q == RUN)) && !eos_seen_q;
  assign host_wready = accept_ok & (~fifo_full | fifo_pop);
  assign fifo_push   = host_wvalid & host_wready;
  assign stop_hit    = stop & (state_q != IDLE);
  // IDLE keeps the buffer empty; stop discards whatever was queued.
  assign fifo_flush  = stop_hit | (state_q == IDLE);

  mp3dec_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (host_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (dec_fifo_datain),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Control state and its bookkeeping registers.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      eos_seen_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      eos_seen_q <= eos_seen_d;
      pend_q     <= pend_d;
    end
  end

  // Next-state logic; stop overrides every other transition.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    pend_d       = pend_q;
    clear_counts = 1'b0;
    eos_seen_d   = eos_seen_q | (fifo_push & host_eos);
    unique case (state_q)
      IDLE: begin
        // pend_q carries a start that arrived in DONE through one IDLE cycle.
        if (start || pend_q) begin
          state_d      = RSTD;
          retry_d      = '0;
          eos_seen_d   = 1'b0;
          pend_d       = 1'b0;
          clear_counts = 1'b1;
        end
      end
      RSTD: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TMR_W'(RST_CYCLES - 1)) begin
          state_d = PRIME;
        end
      end
      PRIME: begin
        if ((fifo_count >= CNT_W'(PRIME_WORDS)) || eos_seen_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (dec_invalid) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = RSTD;
          end else begin
            state_d = ERROR;
          end
        end else if (eos_seen_q && fifo_empty) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        timer_d = gran_edge ? '0 : timer_q + 1'b1;
        if (dec_invalid) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = RSTD;
          end else begin
            state_d = ERROR;
          end
        end else if (!gran_edge && (timer_q == TMR_W'(DRAIN_TMO - 1))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start && !stop) begin
          state_d = IDLE;
          pend_d  = 1'b1;
        end
      end
      ERROR: begin
        state_d = state_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (stop_hit) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end
    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  // Granule edge history and the status counters.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      gran_prev_q <= 1'b0;
      gran_par_q  <= '0;
      frame_q     <= '0;
      underrun_q  <= '0;
    end else begin
      gran_prev_q <= dec_granule_done;
      gran_par_q  <= gran_par_d;
      frame_q     <= frame_d;
      underrun_q  <= underrun_d;
    end
  end

  // Frame counting from granule edges and saturating underrun counting.
  always_comb begin
    gran_par_d = gran_par_q;
    frame_d    = frame_q;
    underrun_d = underrun_q;
    if (clear_counts) begin
      gran_par_d = '0;
      frame_d    = '0;
      underrun_d = '0;
    end else begin
      if (state_q == RSTD) begin
        gran_par_d = '0;
      end else if (gran_edge) begin
        if (gran_par_q == GRAN_CNT_W'(GRANULES_PER_FRAME - 1)) begin
          gran_par_d = '0;
          frame_d    = frame_q + 1'b1;
        end else begin
          gran_par_d = gran_par_q + 1'b1;
        end
      end
      if (dec_fifo_ren && fifo_empty && (underrun_q != 16'hFFFF)) begin
        underrun_d = underrun_q + 1'b1;
      end
    end
  end

  // Decoder-facing controls and status flags decoded from the state.
  always_comb begin
    dec_rst_n      = (state_q == PRIME) || (state_q == RUN) ||
                     (state_q == DRAIN) || (state_q == DONE);
    dec_enable     = (state_q == RUN) || (state_q == DRAIN);
    dec_fifo_empty = fifo_empty | (state_q != RUN);
    dec_wfull      = ((state_q == RUN) || (state_q == DRAIN)) ? sink_full : 1'b1;
    busy           = is_busy(state_q);
    done           = (state_q == DONE);
    error          = (state_q == ERROR);
  end

  assign state_o        = state_q;
  assign frame_count    = frame_q;
  assign underrun_count = underrun_q;

endmodule
